// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin grant sequencer.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_decoder_3to8.sv
// 3:8 binary-to-one-hot decoder used to drive the grant select lines.
module onehot_decoder_3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  assign onehot_o = N_REQ'(1) << idx_i;

endmodule

// File: rtl/grant_sequencer_8.sv
// Registered 8-way round-robin arbiter with hold-until-release and a
// maximum-hold timeout that forces priority rotation.
module grant_sequencer_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_REQ-1:0] Req,
  input  logic             Done,
  output logic [N_REQ-1:0] Grant,
  output logic [IDX_W-1:0] GrantIdx,
  output logic             Valid,
  output logic             Timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic               rel_done, rel_drop, rel_hold, release_now;
  logic [N_REQ-1:0]   dec_onehot;

  // Rotating-priority search: offsets 1..8, so the base itself is checked last.
  always_comb begin
    base  = (state_q == IDLE) ? last_q : idx_q;
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = base + IDX_W'(off);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign rel_done    = Done;
  assign rel_drop    = ~Req[idx_q];
  assign rel_hold    = (cnt_q == CNT_W'(MAX_HOLD));
  assign release_now = rel_done | rel_drop | rel_hold;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = win;
          last_d  = win;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          // Timeout flags only releases forced purely by the hold limit.
          timeout_d = rel_hold & ~rel_done & ~rel_drop;
          if (found) begin
            idx_d  = win;
            last_d = win;
            cnt_d  = CNT_W'(1);
          end else begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  onehot_decoder_3to8 u_dec (
    .idx_i    (idx_q),
    .onehot_o (dec_onehot)
  );

  assign Grant    = dec_onehot & {N_REQ{valid_q}};
  assign GrantIdx = idx_q;
  assign Valid    = valid_q;
  assign Timeout  = timeout_q;

endmodule

// File: tb/tb_grant_sequencer_8.sv
// Randomized self-checking bench for grant_sequencer_8 against a behavioural model.
module tb_grant_sequencer_8;

  localparam int MAXH = 4;

  logic       Clk;
  logic       Rst;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] Grant;
  logic [2:0] GrantIdx;
  logic       Valid;
  logic       Timeout;

  int n_vec;
  int n_err;

  // Reference model state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_valid;
  bit m_to;

  grant_sequencer_8 #(.MAX_HOLD(MAXH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Req      (Req),
    .Done     (Done),
    .Grant    (Grant),
    .GrantIdx (GrantIdx),
    .Valid    (Valid),
    .Timeout  (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 7;
    m_cnt   = 0;
    m_valid = 0;
    m_to    = 0;
  endtask

  // First requester found scanning from start+1 around to start itself; -1 if none.
  function automatic int rr_pick(input logic [7:0] r, input int start);
    for (int k = 1; k <= 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] r, input logic d);
    int  w;
    bit  ra, rb, rc;
    m_to = 0;
    if (!m_valid) begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_valid = 1; m_cnt = 1;
      end
    end else begin
      ra = d;
      rb = !r[m_owner];
      rc = (m_cnt == MAXH);
      if (ra || rb || rc) begin
        m_to = rc && !ra && !rb;
        w = rr_pick(r, m_owner);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_cnt = 1;
        end else begin
          m_valid = 0; m_cnt = 0;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    eg = m_valid ? (8'd1 << m_owner) : 8'd0;
    check_eq({tag, ".grant"},   32'(Grant),    32'(eg));
    check_eq({tag, ".idx"},     32'(GrantIdx), 32'(m_owner));
    check_eq({tag, ".valid"},   32'(Valid),    32'(m_valid));
    check_eq({tag, ".timeout"}, 32'(Timeout),  32'(m_to));
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic d);
    Req  = r;
    Done = d;
    model_edge(r, d);
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #2;
    Rst = 1'b1;
    #1;
    check_eq({tag, ".rst_grant"},   32'(Grant),    32'd0);
    check_eq({tag, ".rst_valid"},   32'(Valid),    32'd0);
    check_eq({tag, ".rst_timeout"}, 32'(Timeout),  32'd0);
    check_eq({tag, ".rst_idx"},     32'(GrantIdx), 32'd0);
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] prev;
    logic       d;
    n_vec = 0;
    n_err = 0;
    Rst  = 1'b1;
    Req  = 8'h00;
    Done = 1'b0;
    model_reset();
    #3;
    check_outputs("por");
    @(negedge Clk);
    Rst = 1'b0;

    // Single request
    step("idle", 8'h00, 1'b0);
    step("single", 8'b0000_0100, 1'b0);
    check_eq("single.idx_const", 32'(GrantIdx), 32'd2);
    check_eq("single.grant_const", 32'(Grant), 32'h04);

    // Reset mid-grant with owner 4, then first grant from requester 0
    do_reset("r0");
    step("own4", 8'h10, 1'b0);
    check_eq("own4.idx_const", 32'(GrantIdx), 32'd4);
    do_reset("r1");
    step("after_rst", 8'hFF, 1'b0);
    check_eq("after_rst.idx_const", 32'(GrantIdx), 32'd0);

    // Full rotation with Done every cycle: 1..7 then wrap to 0
    for (int i = 1; i <= 8; i++) begin
      step("rot", 8'hFF, 1'b1);
      check_eq("rot.idx_const", 32'(GrantIdx), 32'(i % 8));
    end

    // Skip and wrap
    do_reset("r2");
    step("own5", 8'h20, 1'b0);
    step("skip", 8'b0010_0001, 1'b1);
    check_eq("skip.idx_const", 32'(GrantIdx), 32'd0);
    step("wrap", 8'b0010_0001, 1'b1);
    check_eq("wrap.idx_const", 32'(GrantIdx), 32'd5);

    // Timeout after MAX_HOLD cycles, owner regranted
    do_reset("r3");
    for (int i = 0; i < MAXH; i++) begin
      step("hold", 8'b0000_1000, 1'b0);
      check_eq("hold.to_const", 32'(Timeout), 32'd0);
    end
    step("tmo", 8'b0000_1000, 1'b0);
    check_eq("tmo.to_const", 32'(Timeout), 32'd1);
    check_eq("tmo.idx_const", 32'(GrantIdx), 32'd3);
    step("tmo_after", 8'b0000_1000, 1'b0);
    check_eq("tmo_after.to_const", 32'(Timeout), 32'd0);

    // Timeout coinciding with Done must not pulse
    for (int i = 1; i < MAXH; i++) step("hold2", 8'b0000_1000, 1'b0);
    step("tmo_done", 8'b0000_1000, 1'b1);
    check_eq("tmo_done.to_const", 32'(Timeout), 32'd0);

    // Owner drops its request
    do_reset("r4");
    step("own1", 8'b1000_0010, 1'b0);
    step("drop", 8'b1000_0000, 1'b0);
    check_eq("drop.idx_const", 32'(GrantIdx), 32'd7);
    step("go_idle", 8'h00, 1'b0);
    check_eq("go_idle.valid_const", 32'(Valid), 32'd0);
    check_eq("go_idle.idx_kept", 32'(GrantIdx), 32'd7);

    // Randomized traffic
    prev = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom);
        1:       r = prev;
        2:       r = prev ^ (8'd1 << $urandom_range(0, 7));
        default: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      endcase
      d = ($urandom_range(0, 3) == 0);
      step("rand", r, d);
      prev = r;
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
